// File: rtl/counter_share_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : counter_sched_pkg
// Brief   : State encoding, default sizes and round-robin pick helper shared
//           by the counter share scheduler and its counter datapath.
// Revision: 1.0
// ---------------------------------------------------------------------------
package counter_sched_pkg;

  localparam int c_DEFAULT_CW    = 64;
  localparam int c_DEFAULT_N_REQ = 4;
  localparam int c_MAX_REQ       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_e;

  // Lowest set bit at or above ptr, wrapping to the lowest set bit overall.
  // Returns -1 when no request is pending.
  function automatic int rr_pick(input logic [c_MAX_REQ-1:0] req_vec,
                                 input logic [3:0]           ptr);
    logic [c_MAX_REQ-1:0] upper;
    logic [c_MAX_REQ-1:0] cand;
    int                   idx;
    upper = req_vec & ({c_MAX_REQ{1'b1}} << ptr);
    cand  = (upper != '0) ? upper : req_vec;
    idx   = -1;
    for (int i = c_MAX_REQ - 1; i >= 0; i--) begin
      if (cand[i]) idx = i;
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_share_scheduler_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sched_up_counter
// Brief   : Loadable CW-bit up counter clocked on the falling edge.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sched_up_counter
  import counter_sched_pkg::*;
#(
  parameter int CW = c_DEFAULT_CW
) (
  input  logic          clock0,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          inc_en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] r_count;

  // Load wins over increment; with neither the value holds.
  always_ff @(negedge clock0) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (inc_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/counter_share_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : counter_share_scheduler
// Brief   : Round-robin owner of one shared up counter; runs the owner's
//           requested interval and pulses done on completion.
// Revision: 1.0
// ---------------------------------------------------------------------------
module counter_share_scheduler
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = c_DEFAULT_N_REQ,
  parameter int CW    = c_DEFAULT_CW
) (
  input  logic                clock0,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*CW-1:0] req_len,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    done,
  output logic                busy,
  output logic [CW-1:0]       count_value
);

  localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  sched_state_e     r_state;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;
  logic             r_busy;
  logic [c_IW-1:0]  r_owner;
  logic [c_IW-1:0]  r_rr_ptr;
  logic [CW-1:0]    r_len_q;

  int               w_pick;
  logic             w_pick_valid;
  logic [c_IW-1:0]  w_pick_idx;
  logic [CW-1:0]    w_sel_len;
  logic             w_owner_req;
  logic [c_IW-1:0]  w_next_ptr;
  logic             w_at_len;
  logic             w_cnt_load;
  logic             w_cnt_inc;

  always_comb begin
    w_pick       = rr_pick(c_MAX_REQ'(req), 4'(r_rr_ptr));
    w_pick_valid = (w_pick >= 0);
    w_pick_idx   = c_IW'(w_pick);
    w_sel_len    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == c_IW'(i)) w_sel_len = req_len[i*CW +: CW];
    end
  end

  // The owner is tracked through the one-hot grant so a dropped req aborts.
  assign w_owner_req = |(req & r_grant);
  assign w_next_ptr  = (r_owner == c_IW'(N_REQ - 1)) ? '0 : r_owner + c_IW'(1);
  assign w_at_len    = (count_value == r_len_q);
  assign w_cnt_load  = (r_state == LOAD) && w_owner_req;
  assign w_cnt_inc   = (r_state == RUN) && w_owner_req && !w_at_len;

  always_ff @(negedge clock0) begin
    if (reset) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_len_q  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_owner <= w_pick_idx;
            r_grant <= N_REQ'(1) << w_pick_idx;
            r_len_q <= w_sel_len;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD, RUN: begin
          if (!w_owner_req) begin
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end else if (r_state == LOAD) begin
            r_state <= RUN;
          end else if (w_at_len) begin
            r_done  <= r_grant;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_grant  <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
          r_state  <= IDLE;
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  sched_up_counter #(
    .CW (CW)
  ) u_counter (
    .clock0     (clock0),
    .reset      (reset),
    .load       (w_cnt_load),
    .load_value ('0),
    .inc_en     (w_cnt_inc),
    .count      (count_value)
  );

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_counter_share_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_counter_share_scheduler
// Brief   : Directed self-checking bench for the counter share scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_counter_share_scheduler;

  localparam int N   = 4;
  localparam int CW  = 64;
  localparam int CW8 = 8;

  logic            clock0 = 1'b1;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] req_len;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [CW-1:0]   count_value;

  logic [N-1:0]     req8;
  logic [N*CW8-1:0] req_len8;
  logic [N-1:0]     grant8;
  logic [N-1:0]     done8;
  logic             busy8;
  logic [CW8-1:0]   count8;

  int total = 0;
  int bad   = 0;

  always #5 clock0 = ~clock0;

  counter_share_scheduler #(.N_REQ(N), .CW(CW)) dut (
    .clock0(clock0), .reset(reset), .req(req), .req_len(req_len),
    .grant(grant), .done(done), .busy(busy), .count_value(count_value)
  );

  counter_share_scheduler #(.N_REQ(N), .CW(CW8)) dut8 (
    .clock0(clock0), .reset(reset), .req(req8), .req_len(req_len8),
    .grant(grant8), .done(done8), .busy(busy8), .count_value(count8)
  );

  // Active edge is the negedge; the posedge is used to sample and drive.
  task automatic step;
    @(posedge clock0);
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0; req_len = '0; req8 = '0; req_len8 = '0;
    step; step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", grant); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL rst_done got=%b want=0000", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (count_value !== 64'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count_value); end
    total++; if (count8 !== 8'd0) begin bad++; $display("FAIL rst_count8 got=%0d want=0", count8); end
  endtask

  task automatic test_single;
    logic [CW-1:0] exp_cnt;
    reset = 1'b0;
    req_len[0*CW +: CW] = 64'd5;
    req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      step;
      exp_cnt = (c < 2) ? 64'd0 : ((c - 2 > 5) ? 64'd5 : 64'(c - 2));
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant c=%0d got=%b want=0001", c, grant); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy c=%0d got=%b want=1", c, busy); end
      total++; if (count_value !== exp_cnt) begin bad++; $display("FAIL single_count c=%0d got=%0d want=%0d", c, count_value, exp_cnt); end
      total++; if (done !== ((c == 8) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL single_done c=%0d got=%b", c, done); end
    end
    req = 4'b0000;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_release got=%b want=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_fall got=%b want=0", busy); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_once got=%b want=0000", done); end
  endtask

  task automatic test_fairness;
    logic [N-1:0] exp_g;
    reset = 1'b1; step; reset = 1'b0;
    for (int i = 0; i < N; i++) req_len[i*CW +: CW] = 64'd2;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % N);
      for (int c = 1; c <= 5; c++) begin
        step;
        total++; if (grant !== exp_g) begin bad++; $display("FAIL fair_grant g=%0d c=%0d got=%b want=%b", g, c, grant, exp_g); end
        total++; if (done !== ((c == 5) ? exp_g : 4'b0000)) begin bad++; $display("FAIL fair_done g=%0d c=%0d got=%b", g, c, done); end
      end
      step;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL fair_idle g=%0d got=%b want=0000", g, grant); end
      if (g == 4) req = 4'b0000;
    end
  endtask

  task automatic test_zero_len;
    req_len[2*CW +: CW] = 64'd0;
    req = 4'b0100;
    for (int c = 1; c <= 3; c++) begin
      step;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL zero_grant c=%0d got=%b want=0100", c, grant); end
      total++; if (done !== ((c == 3) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL zero_done c=%0d got=%b", c, done); end
      if (c >= 2) begin
        total++; if (count_value !== 64'd0) begin bad++; $display("FAIL zero_count c=%0d got=%0d want=0", c, count_value); end
      end
    end
    req = 4'b0000;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL zero_release got=%b want=0000", grant); end
  endtask

  task automatic test_abort;
    bit found;
    req_len[1*CW +: CW] = 64'd100;
    req_len[2*CW +: CW] = 64'd1;
    req = 4'b0110;
    step;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL abort_grant got=%b want=0010", grant); end
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step;
      if (count_value == 64'd10) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL abort_reach10 got=%0d want=10", count_value); end
    req = 4'b0100;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL abort_grant_drop got=%b want=0000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", busy); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL abort_no_done got=%b want=0000", done); end
    total++; if (count_value !== 64'd10) begin bad++; $display("FAIL abort_hold got=%0d want=10", count_value); end
    for (int c = 1; c <= 4; c++) begin
      step;
      total++; if (grant !== 4'b0100) begin bad++; $display("FAIL abort_next_grant c=%0d got=%b want=0100", c, grant); end
      total++; if (done !== ((c == 4) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL abort_next_done c=%0d got=%b", c, done); end
    end
    req = 4'b0000;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL abort_next_release got=%b want=0000", grant); end
  endtask

  task automatic test_reset_mid_run;
    bit found;
    req_len[0*CW +: CW] = 64'd20;
    req = 4'b0001;
    step;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL midrst_grant got=%b want=0001", grant); end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step;
      if (count_value == 64'd7) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL midrst_reach7 got=%0d want=7", count_value); end
    reset = 1'b1;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL midrst_grant0 got=%b want=0000", grant); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL midrst_done0 got=%b want=0000", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy0 got=%b want=0", busy); end
    total++; if (count_value !== 64'd0) begin bad++; $display("FAIL midrst_count0 got=%0d want=0", count_value); end
    reset = 1'b0;
    req_len[1*CW +: CW] = 64'd2;
    req_len[3*CW +: CW] = 64'd2;
    req = 4'b1010;
    step;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL midrst_first got=%b want=0010", grant); end
    req = 4'b0000;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL midrst_abort got=%b want=0000", grant); end
  endtask

  task automatic test_len_change;
    req_len[0*CW +: CW] = 64'd9;
    req = 4'b0001;
    step;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL lenchg_grant got=%b want=0001", grant); end
    req_len[0*CW +: CW] = 64'd3;
    for (int c = 2; c <= 12; c++) begin
      step;
      total++; if (done !== ((c == 12) ? 4'b0001 : 4'b0000)) begin bad++; $display("FAIL lenchg_done c=%0d got=%b", c, done); end
    end
    total++; if (count_value !== 64'd9) begin bad++; $display("FAIL lenchg_count got=%0d want=9", count_value); end
    req = 4'b0000;
    step;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL lenchg_release got=%b want=0000", grant); end
  endtask

  task automatic test_wide;
    int       done_c;
    bit       wrapped;
    logic [CW8-1:0] prev;
    req_len8[0*CW8 +: CW8] = 8'hFF;
    req8 = 4'b0001;
    step;
    total++; if (grant8 !== 4'b0001) begin bad++; $display("FAIL wide_grant got=%b want=0001", grant8); end
    done_c  = 0;
    wrapped = 1'b0;
    prev    = count8;
    for (int c = 2; c <= 300 && done_c == 0; c++) begin
      step;
      if (count8 < prev) wrapped = 1'b1;
      prev = count8;
      if (done8 != 4'b0000) done_c = c;
    end
    total++; if (done_c != 258) begin bad++; $display("FAIL wide_done_cycle got=%0d want=258", done_c); end
    total++; if (count8 !== 8'hFF) begin bad++; $display("FAIL wide_count got=%0d want=255", count8); end
    total++; if (wrapped) begin bad++; $display("FAIL wide_wrap got=1 want=0"); end
    req8 = 4'b0000;
    step;
    total++; if (grant8 !== 4'b0000) begin bad++; $display("FAIL wide_release got=%b want=0000", grant8); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_zero_len;
    test_abort;
    test_reset_mid_run;
    test_len_change;
    test_wide;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
